isa_io_cycle_controller: RTL and testbench
==========================================

# isa_io_cycle_controller

Sequences a single ISA I/O read or write cycle through the 16-bit bus-interface datapath (address/data holding registers plus IOW/IOR strobes) on behalf of the HPS-side register file. It accepts one command at a time over a valid/ready handshake and generates the datapath controls with programmable setup, strobe, hold and recovery timing. It stretches the strobe while the card holds IOCHRDY low, and aborts with a timeout flag if the card never releases it. It sits between the HPS Avalon slave logic and the bus interface, and is the only driver of that datapath's load and strobe inputs.

## Interface
- SETUP_CYCLES, 2, address-valid to strobe-asserted delay in clk cycles (>=1)
- STROBE_CYCLES, 8, minimum strobe-low width in cycles (>=2)
- HOLD_CYCLES, 1, strobe-deasserted cycles before the response (>=1)
- RECOVERY_CYCLES, 4, idle cycles after the response before the next command is accepted (>=0)
- TIMEOUT_CYCLES, 1024, maximum IOCHRDY-low wait cycles (>=1)
- CNT_WIDTH, 11, phase counter width; must hold max(all cycle parameters)
- clk  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request; address/data already present on the HPS-side datapath inputs
- cmd_write  in  1  1 = I/O write, 0 = I/O read; sampled at accept
- cmd_ready  out  1  controller idle, command accepted when cmd_valid & cmd_ready
- iochrdy  in  1  ISA channel ready, asynchronous; 0 = card requests wait states
- address_load  out  1  one-cycle load pulse to the address register
- data_load  out  1  one-cycle load pulse to the write-data register (writes only)
- data_read  out  1  one-cycle capture pulse to the read-data register (reads only)
- iow  out  1  active-low I/O write strobe
- ior  out  1  active-low I/O read strobe
- rsp_valid  out  1  one-cycle pulse: cycle complete, read data valid on the datapath HPS output
- rsp_timeout  out  1  qualifies rsp_valid: cycle aborted by IOCHRDY timeout
- busy  out  1  inverse of cmd_ready

## Operation
- All outputs are registered. Reset values: cmd_ready=1, busy=0, iow=1, ior=1, and all other outputs 0. The state machine resets to IDLE and all counters to 0.
- iochrdy passes through a 2-flop synchronizer (iochrdy_s, reset value 1). The state machine only uses iochrdy_s.
- IDLE: cmd_ready=1. On accept, latch cmd_write and go to LOAD.
- LOAD: 1 cycle. address_load=1; data_load=cmd_write. Go to SETUP.
- SETUP: SETUP_CYCLES cycles, strobes high. Go to STROBE.
- STROBE: iow=0 (write) or ior=0 (read) for STROBE_CYCLES-1 cycles.
  - In the final counted cycle: iochrdy_s=1 goes to LAST; iochrdy_s=0 goes to WAIT.
- WAIT: strobe held low. Each cycle increments the wait counter.
  - iochrdy_s=1 goes to LAST.
  - When the counter reaches TIMEOUT_CYCLES: set the timeout flag and go to HOLD directly; data_read is never pulsed.
- LAST: 1 cycle, strobe still low. data_read=1 if read. Go to HOLD.
- HOLD: HOLD_CYCLES cycles, strobes high. rsp_valid=1 in the final HOLD cycle, with rsp_timeout=flag. Go to RECOVERY, or to IDLE if RECOVERY_CYCLES=0.
- RECOVERY: RECOVERY_CYCLES cycles. Then go to IDLE and clear the flag.
- iow and ior are never low simultaneously. data_load, address_load and data_read are never asserted outside LOAD/LAST.
- cmd_valid is ignored outside IDLE; there is no queueing. A new command is accepted no earlier than the first IDLE cycle after RECOVERY.
- Reset asserted mid-cycle forces iow=ior=1 and the state to IDLE immediately (asynchronously). No rsp_valid is generated for the aborted cycle.

## Timing
- Accept at edge T0 (cmd_valid & cmd_ready high in cycle 0).
  - LOAD = cycle 1
  - SETUP = cycles 2..1+SETUP_CYCLES
  - strobe low from cycle 2+SETUP_CYCLES
- Strobe-low width = STROBE_CYCLES + W, where W is the number of WAIT cycles.
- Because of the synchronizer, iochrdy must fall at least 2 cycles before the final STROBE cycle to extend the strobe.
- With defaults, W=0, the cycle runs:
  - LOAD = cycle 1
  - iow/ior low in cycles 4-11
  - data_read in cycle 11
  - rsp_valid in cycle 12
  - RECOVERY = cycles 13-16
  - cmd_ready=1 again in cycle 17
- Command-to-command period = 1 + 1 + SETUP + STROBE + W + HOLD + RECOVERY cycles (17 with defaults).
- A timeout cycle holds the strobe low for STROBE_CYCLES-1+TIMEOUT_CYCLES cycles, then follows the normal HOLD/RECOVERY sequence.

## Test plan
- Reset, then write with iochrdy=1 -> address_load and data_load in cycle 1 only; iow low exactly cycles 4-11; ior stays 1; rsp_valid in cycle 12 with rsp_timeout=0; cmd_ready back in cycle 17.
- Read with iochrdy=1 -> ior low cycles 4-11; data_read in cycle 11 only; data_load never asserts; rsp_valid in cycle 12.
- Read with iochrdy driven low from cycle 5 to cycle 20 -> ior stays low until iochrdy_s rises (cycle 22); data_read in the LAST cycle; rsp_valid one cycle later; strobe width = 8 + W.
- Write with iochrdy stuck low, TIMEOUT_CYCLES=16 -> iow low for 23 cycles; no data_read; rsp_valid with rsp_timeout=1; the next command completes normally with rsp_timeout=0.
- cmd_valid held high continuously -> exactly one accept per 17-cycle period; busy=~cmd_ready throughout.
- Reset asserted during WAIT -> iow/ior return to 1 without waiting for a clk edge; no rsp_valid; cmd_ready=1 after release; a subsequent read completes normally.

Source files
------------

// File: rtl/isa_io_cycle_controller.sv
// ISA I/O cycle sequencer: drives address/data load, IOW/IOR strobes and read capture
// for one bus cycle at a time, with programmable timing and IOCHRDY wait/timeout.
module isa_io_cycle_controller #(
   parameter int SETUP_CYCLES    = 2,
   parameter int STROBE_CYCLES   = 8,
   parameter int HOLD_CYCLES     = 1,
   parameter int RECOVERY_CYCLES = 4,
   parameter int TIMEOUT_CYCLES  = 1024,
   parameter int CNT_WIDTH       = 11
) (
   input  logic clk,
   input  logic reset,
   input  logic cmd_valid,
   input  logic cmd_write,
   output logic cmd_ready,
   input  logic iochrdy,
   output logic address_load,
   output logic data_load,
   output logic data_read,
   output logic iow,
   output logic ior,
   output logic rsp_valid,
   output logic rsp_timeout,
   output logic busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SETUP,
      S_STROBE,
      S_WAIT,
      S_LAST,
      S_HOLD,
      S_RECOVERY
   } state_t;

   // Terminal counts: each phase counts from 0 up to its *_END value.
   // STROBE stops one short because LAST supplies the final strobe-low cycle.
   localparam logic [CNT_WIDTH-1:0] SETUP_END    = CNT_WIDTH'(SETUP_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] STROBE_END   = CNT_WIDTH'(STROBE_CYCLES - 2);
   localparam logic [CNT_WIDTH-1:0] HOLD_END     = CNT_WIDTH'(HOLD_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] RECOVERY_END = CNT_WIDTH'(RECOVERY_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] TIMEOUT_END  = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

   state_t               state, state_nxt;
   logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
   logic                 write_q, write_nxt;
   logic                 timeout_q, timeout_nxt;
   logic                 iochrdy_m, iochrdy_s;
   logic                 strobe_nxt;
   logic                 rsp_nxt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         iochrdy_m <= 1'b1;
         iochrdy_s <= 1'b1;
      end else begin
         iochrdy_m <= iochrdy;
         iochrdy_s <= iochrdy_m;
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt + CNT_WIDTH'(1);
      write_nxt   = write_q;
      timeout_nxt = timeout_q;
      case (state)
         S_IDLE: begin
            cnt_nxt = '0;
            if (cmd_valid) begin
               state_nxt = S_LOAD;
               write_nxt = cmd_write;
            end
         end
         S_LOAD: begin
            cnt_nxt   = '0;
            state_nxt = S_SETUP;
         end
         S_SETUP: begin
            if (cnt == SETUP_END) begin
               cnt_nxt   = '0;
               state_nxt = S_STROBE;
            end
         end
         S_STROBE: begin
            if (cnt == STROBE_END) begin
               cnt_nxt   = '0;
               state_nxt = iochrdy_s ? S_LAST : S_WAIT;
            end
         end
         S_WAIT: begin
            // A card release on the very last allowed wait cycle still wins over timeout.
            if (iochrdy_s) begin
               cnt_nxt   = '0;
               state_nxt = S_LAST;
            end else if (cnt == TIMEOUT_END) begin
               cnt_nxt     = '0;
               timeout_nxt = 1'b1;
               state_nxt   = S_HOLD;
            end
         end
         S_LAST: begin
            cnt_nxt   = '0;
            state_nxt = S_HOLD;
         end
         S_HOLD: begin
            if (cnt == HOLD_END) begin
               cnt_nxt = '0;
               if (RECOVERY_CYCLES == 0) begin
                  state_nxt   = S_IDLE;
                  timeout_nxt = 1'b0;
               end else begin
                  state_nxt = S_RECOVERY;
               end
            end
         end
         S_RECOVERY: begin
            if (cnt == RECOVERY_END) begin
               cnt_nxt     = '0;
               timeout_nxt = 1'b0;
               state_nxt   = S_IDLE;
            end
         end
         default: begin
            cnt_nxt   = '0;
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Outputs are decoded from the next state so the registered copies line up with the state.
   assign strobe_nxt = (state_nxt == S_STROBE) || (state_nxt == S_WAIT) || (state_nxt == S_LAST);
   assign rsp_nxt    = (state_nxt == S_HOLD) && (cnt_nxt == HOLD_END);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= S_IDLE;
         cnt          <= '0;
         write_q      <= 1'b0;
         timeout_q    <= 1'b0;
         cmd_ready    <= 1'b1;
         busy         <= 1'b0;
         address_load <= 1'b0;
         data_load    <= 1'b0;
         data_read    <= 1'b0;
         iow          <= 1'b1;
         ior          <= 1'b1;
         rsp_valid    <= 1'b0;
         rsp_timeout  <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         write_q      <= write_nxt;
         timeout_q    <= timeout_nxt;
         cmd_ready    <= (state_nxt == S_IDLE);
         busy         <= (state_nxt != S_IDLE);
         address_load <= (state_nxt == S_LOAD);
         data_load    <= (state_nxt == S_LOAD) && write_nxt;
         data_read    <= (state_nxt == S_LAST) && !write_nxt;
         iow          <= !(strobe_nxt && write_nxt);
         ior          <= !(strobe_nxt && !write_nxt);
         rsp_valid    <= rsp_nxt;
         rsp_timeout  <= rsp_nxt && timeout_nxt;
      end
   end

endmodule

// File: tb/tb_isa_io_cycle_controller.sv
// Bench for isa_io_cycle_controller: timeline model derived from the cycle rules,
// per-cycle comparison of every output, plus hand-computed cycle numbers.
module tb_isa_io_cycle_controller;

   localparam int SETUP  = 2;
   localparam int STROBE = 8;
   localparam int HOLD   = 1;
   localparam int REC    = 4;
   localparam int TMO    = 16;
   localparam int N      = 128;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic cmd_valid = 1'b0;
   logic cmd_write = 1'b0;
   logic iochrdy = 1'b1;
   logic cmd_ready, address_load, data_load, data_read, iow, ior, rsp_valid, rsp_timeout, busy;

   int errors = 0;
   int checks = 0;

   bit stim_vld [N];
   bit stim_wr  [N];
   bit stim_rdy [N];

   bit e_ready  [N];
   bit e_aload  [N];
   bit e_dload  [N];
   bit e_dread  [N];
   bit e_iow_lo [N];
   bit e_ior_lo [N];
   bit e_rsp    [N];
   bit e_rto    [N];

   int  obs_first_lo, obs_lo_cnt, obs_rsp_cyc, obs_dread_cyc;
   int  obs_rto_cnt, obs_rto_cyc, obs_accepts, obs_ready_back;
   bit  obs_seen_busy;

   isa_io_cycle_controller #(
      .SETUP_CYCLES   (SETUP),
      .STROBE_CYCLES  (STROBE),
      .HOLD_CYCLES    (HOLD),
      .RECOVERY_CYCLES(REC),
      .TIMEOUT_CYCLES (TMO),
      .CNT_WIDTH      (11)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .cmd_valid   (cmd_valid),
      .cmd_write   (cmd_write),
      .cmd_ready   (cmd_ready),
      .iochrdy     (iochrdy),
      .address_load(address_load),
      .data_load   (data_load),
      .data_read   (data_read),
      .iow         (iow),
      .ior         (ior),
      .rsp_valid   (rsp_valid),
      .rsp_timeout (rsp_timeout),
      .busy        (busy)
   );

   always #10 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int cyc, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, got, exp);
      end
   endtask

   // iochrdy driven during cycle k is seen by the state machine in cycle k+2.
   function automatic bit sync_at(input int k);
      return (k < 2) ? 1'b1 : stim_rdy[k-2];
   endfunction

   // Builds the whole expected timeline of one command accepted in cycle c0.
   task automatic model_txn(input int c0, input bit wr);
      int ss, fs, lst, last_lo, h, done;
      bit to;
      ss = c0 + 2 + SETUP;
      fs = ss + STROBE - 2;
      to = 1'b0;
      lst = -1;
      if (sync_at(fs)) lst = fs + 1;
      else
         for (int j = 1; j <= TMO; j++)
            if (lst < 0 && sync_at(fs + j)) lst = fs + j + 1;
      if (lst < 0) begin
         to = 1'b1;
         last_lo = fs + TMO;
      end else begin
         last_lo = lst;
      end
      h = last_lo + 1;
      done = h + HOLD + REC;
      for (int k = c0 + 1; k < done && k < N; k++) e_ready[k] = 1'b0;
      e_aload[c0+1] = 1'b1;
      e_dload[c0+1] = wr;
      for (int k = ss; k <= last_lo && k < N; k++)
         if (wr) e_iow_lo[k] = 1'b1;
         else    e_ior_lo[k] = 1'b1;
      if (!to && !wr) e_dread[lst] = 1'b1;
      e_rsp[h+HOLD-1] = 1'b1;
      e_rto[h+HOLD-1] = to;
   endtask

   task automatic seg_begin();
      for (int k = 0; k < N; k++) begin
         stim_vld[k] = 1'b0; stim_wr[k] = 1'b0; stim_rdy[k] = 1'b1;
         e_ready[k] = 1'b1; e_aload[k] = 1'b0; e_dload[k] = 1'b0; e_dread[k] = 1'b0;
         e_iow_lo[k] = 1'b0; e_ior_lo[k] = 1'b0; e_rsp[k] = 1'b0; e_rto[k] = 1'b0;
      end
      obs_first_lo = -1; obs_lo_cnt = 0; obs_rsp_cyc = -1; obs_dread_cyc = -1;
      obs_rto_cnt = 0; obs_rto_cyc = -1; obs_accepts = 0; obs_ready_back = -1;
      obs_seen_busy = 1'b0;
      cmd_valid = 1'b0; cmd_write = 1'b0; iochrdy = 1'b1;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #5;
      check("rst_cmd_ready", -1, cmd_ready, 1);
      check("rst_busy", -1, busy, 0);
      check("rst_iow", -1, iow, 1);
      check("rst_ior", -1, ior, 1);
      check("rst_address_load", -1, address_load, 0);
      check("rst_data_load", -1, data_load, 0);
      check("rst_data_read", -1, data_read, 0);
      check("rst_rsp_valid", -1, rsp_valid, 0);
      check("rst_rsp_timeout", -1, rsp_timeout, 0);
      #1 reset = 1'b1;
   endtask

   // Cycle k runs from posedge k to posedge k+1; inputs change just after the edge,
   // outputs are compared on the falling edge.
   task automatic run(input int len, input int rst_at);
      for (int k = 0; k < len; k++) begin
         @(posedge clk);
         #1;
         cmd_valid = stim_vld[k];
         cmd_write = stim_wr[k];
         iochrdy   = stim_rdy[k];
         if (e_ready[k] && stim_vld[k]) model_txn(k, stim_wr[k]);
         if (k == rst_at) begin
            #4;
            reset = 1'b0;
            #1;
            check("async_iow", k, iow, 1);
            check("async_ior", k, ior, 1);
            check("async_cmd_ready", k, cmd_ready, 1);
            check("async_busy", k, busy, 0);
            check("async_rsp_valid", k, rsp_valid, 0);
            cmd_valid = 1'b0;
            iochrdy = 1'b1;
            return;
         end
         @(negedge clk);
         check("cmd_ready", k, cmd_ready, e_ready[k]);
         check("busy", k, busy, !e_ready[k]);
         check("address_load", k, address_load, e_aload[k]);
         check("data_load", k, data_load, e_dload[k]);
         check("data_read", k, data_read, e_dread[k]);
         check("iow", k, iow, !e_iow_lo[k]);
         check("ior", k, ior, !e_ior_lo[k]);
         check("rsp_valid", k, rsp_valid, e_rsp[k]);
         check("rsp_timeout", k, rsp_timeout, e_rto[k]);
         if (!iow || !ior) begin
            obs_lo_cnt++;
            if (obs_first_lo < 0) obs_first_lo = k;
         end
         if (data_read) obs_dread_cyc = k;
         if (rsp_valid) begin
            obs_rsp_cyc = k;
            if (rsp_timeout) begin
               obs_rto_cnt++;
               obs_rto_cyc = k;
            end
         end
         if (cmd_ready && cmd_valid) obs_accepts++;
         if (busy) obs_seen_busy = 1'b1;
         if (cmd_ready && obs_seen_busy && obs_ready_back < 0) obs_ready_back = k;
      end
   endtask

   initial begin
      // Write, card always ready.
      seg_begin();
      stim_vld[0] = 1'b1; stim_wr[0] = 1'b1;
      run(24, -1);
      check("wr_first_iow_low", 0, obs_first_lo, 4);
      check("wr_iow_low_cycles", 0, obs_lo_cnt, 8);
      check("wr_rsp_cycle", 0, obs_rsp_cyc, 12);
      check("wr_ready_back", 0, obs_ready_back, 17);
      check("wr_no_data_read", 0, obs_dread_cyc, -1);

      // Read, card always ready.
      seg_begin();
      stim_vld[0] = 1'b1; stim_wr[0] = 1'b0;
      run(24, -1);
      check("rd_ior_low_cycles", 0, obs_lo_cnt, 8);
      check("rd_data_read_cycle", 0, obs_dread_cyc, 11);
      check("rd_rsp_cycle", 0, obs_rsp_cyc, 12);

      // Read with iochrdy low in cycles 5..19: iochrdy_s back high in cycle 22, LAST in 23.
      seg_begin();
      stim_vld[0] = 1'b1; stim_wr[0] = 1'b0;
      for (int k = 5; k < 20; k++) stim_rdy[k] = 1'b0;
      run(34, -1);
      check("wait_ior_low_cycles", 0, obs_lo_cnt, 20);
      check("wait_data_read_cycle", 0, obs_dread_cyc, 23);
      check("wait_rsp_cycle", 0, obs_rsp_cyc, 24);

      // Write with iochrdy stuck low -> timeout, then a normal read at cycle 34.
      seg_begin();
      stim_vld[0] = 1'b1; stim_wr[0] = 1'b1;
      for (int k = 0; k < 30; k++) stim_rdy[k] = 1'b0;
      stim_vld[34] = 1'b1; stim_wr[34] = 1'b0;
      run(50, -1);
      check("tmo_rsp_timeout_count", 0, obs_rto_cnt, 1);
      check("tmo_rsp_cycle", 0, obs_rto_cyc, 27);
      check("tmo_strobe_low_total", 0, obs_lo_cnt, 23 + 8);
      check("tmo_next_rsp_cycle", 0, obs_rsp_cyc, 46);
      check("tmo_next_data_read", 0, obs_dread_cyc, 45);

      // cmd_valid held high: accepts at cycles 0, 17, 34, 51.
      seg_begin();
      for (int k = 0; k < 53; k++) begin
         stim_vld[k] = 1'b1;
         stim_wr[k] = k[0];
      end
      run(53, -1);
      check("cont_accepts", 0, obs_accepts, 4);

      // Reset asserted mid-cycle while the read is waiting on iochrdy.
      seg_begin();
      stim_vld[0] = 1'b1; stim_wr[0] = 1'b0;
      for (int k = 0; k < 60; k++) stim_rdy[k] = 1'b0;
      run(20, 15);
      check("abort_no_rsp", 0, obs_rsp_cyc, -1);

      // Read after the abort completes normally.
      seg_begin();
      stim_vld[0] = 1'b1; stim_wr[0] = 1'b0;
      run(20, -1);
      check("post_data_read_cycle", 0, obs_dread_cyc, 11);
      check("post_rsp_cycle", 0, obs_rsp_cyc, 12);
      check("post_ready_back", 0, obs_ready_back, 17);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
